console_uart_tx: RTL and testbench

//   Console output controller. Takes the core's single-cycle console writes (console_we/console_wdata),

---
 rtl/console_uart_tx_pkg.sv | 20 ++
 rtl/console_fifo.sv | 58 +++++
 rtl/console_uart_tx.sv | 160 ++++++++++++++++
 tb/tb_console_uart_tx.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/console_uart_tx_pkg.sv
// Shared types and constants for the console UART transmitter.
// The state encodings are also used by simulation loggers to print state names.
package console_uart_tx_pkg;

    localparam int UART_STATE_LEN = 2;
    localparam int BITS_PER_CHAR  = 8;

    typedef enum logic [UART_STATE_LEN-1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_e;

    // Width of a counter that must hold 0..clks-1.
    function automatic int baud_width(input int clks);
        return (clks > 1) ? $clog2(clks) : 1;
    endfunction

endpackage

// File: rtl/console_fifo.sv
// Synchronous first-word-fall-through FIFO; rdata always shows the head entry.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module console_fifo #(
    parameter int FIFO_AW = 4,
    parameter int WIDTH   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic [WIDTH-1:0]   wdata,
    output logic [WIDTH-1:0]   rdata,
    output logic               full,
    output logic               empty,
    output logic [FIFO_AW:0]   count
);

    localparam int DEPTH = 1 << FIFO_AW;

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               do_push, do_pop;

    assign full  = (count_q == (FIFO_AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop & ~empty;
        do_push  = push & (~full | do_pop);
        wr_ptr_d = wr_ptr_q + FIFO_AW'(do_push);
        rd_ptr_d = rd_ptr_q + FIFO_AW'(do_pop);
        count_d  = count_q + (FIFO_AW+1)'(do_push) - (FIFO_AW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/console_uart_tx.sv
// Console output: queues core console writes and sends each byte as 8N1 UART on tx.
// The core cannot stall, so writes into a full queue are dropped and flagged by overflow.
module console_uart_tx
    import console_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_AW      = 4,
    parameter int XLEN         = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              console_we,
    input  logic [XLEN-1:0]   console_wdata,
    output logic              tx,
    output logic              busy,
    output logic              overflow,
    output logic [FIFO_AW:0]  fifo_count,
    output logic              frame_done
);

    localparam int BAUD_W = baud_width(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);

    uart_state_e             state_q, state_d;
    logic [BAUD_W-1:0]       baud_q, baud_d;
    logic [2:0]              bit_q, bit_d;
    logic [7:0]              shift_q, shift_d;
    logic                    tx_q, tx_d;
    logic                    busy_q, busy_d;
    logic                    overflow_q, overflow_d;
    logic                    frame_done_q, frame_done_d;

    logic                    fifo_full, fifo_empty, pop, push_ok, baud_wrap;
    logic [7:0]              fifo_rdata;
    logic [FIFO_AW:0]        count_next;
    logic                    unused_wdata_hi;

    assign unused_wdata_hi = ^console_wdata[XLEN-1:8];

    console_fifo #(
        .FIFO_AW (FIFO_AW),
        .WIDTH   (8)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_ok),
        .pop   (pop),
        .wdata (console_wdata[7:0]),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d      = state_q;
        baud_d       = baud_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        tx_d         = tx_q;
        frame_done_d = 1'b0;
        pop          = 1'b0;
        baud_wrap    = (baud_q == BAUD_LAST);

        case (state_q)
            UART_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_rdata;
                    bit_d   = '0;
                    baud_d  = '0;
                    tx_d    = 1'b0;
                    state_d = UART_START;
                end
            end
            UART_START: begin
                if (baud_wrap) begin
                    baud_d  = '0;
                    tx_d    = shift_q[0];
                    state_d = UART_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            UART_DATA: begin
                if (baud_wrap) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'(BITS_PER_CHAR - 1)) begin
                        tx_d    = 1'b1;
                        state_d = UART_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                        tx_d  = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            UART_STOP: begin
                // Registered pulse must land on the last stop cycle, so raise it one count early.
                frame_done_d = (baud_q == BAUD_PRE);
                if (baud_wrap) begin
                    baud_d = '0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_rdata;
                        bit_d   = '0;
                        tx_d    = 1'b0;
                        state_d = UART_START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = UART_IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = UART_IDLE;
            end
        endcase

        push_ok    = console_we & (~fifo_full | pop);
        overflow_d = overflow_q | (console_we & ~push_ok);
        count_next = fifo_count + (FIFO_AW+1)'(push_ok) - (FIFO_AW+1)'(pop);
        busy_d     = (state_d != UART_IDLE) | (count_next != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= UART_IDLE;
            baud_q       <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            overflow_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            baud_q       <= baud_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            overflow_q   <= overflow_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign overflow   = overflow_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_console_uart_tx.sv
// Self-checking bench for console_uart_tx: directed scenarios followed by random traffic,
// every cycle compared against a frame-timeline model of the UART output.
module tb_console_uart_tx;

    localparam int CPB   = 4;
    localparam int AW    = 2;
    localparam int XLEN  = 32;
    localparam int DEPTH = 1 << AW;
    localparam int FRAME = 10 * CPB;
    localparam int LOGN  = 20000;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            console_we = 1'b0;
    logic [XLEN-1:0] console_wdata = '0;
    logic            tx, busy, overflow, frame_done;
    logic [AW:0]     fifo_count;

    always #5 clk = ~clk;

    console_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_AW      (AW),
        .XLEN         (XLEN)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .console_we    (console_we),
        .console_wdata (console_wdata),
        .tx            (tx),
        .busy          (busy),
        .overflow      (overflow),
        .fifo_count    (fifo_count),
        .frame_done    (frame_done)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Model: queue of accepted bytes plus the start edge of the frame on the wire.
    logic [7:0] mq[$];
    bit         m_active = 0;
    int         m_start  = 0;
    logic [7:0] m_byte   = '0;
    bit         m_ovf    = 0;

    logic tx_log   [LOGN];
    logic fd_log   [LOGN];
    logic busy_log [LOGN];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_edge(input logic we, input logic [31:0] d, input logic rst);
        cyc++;
        if (rst) begin
            mq.delete();
            m_active = 0;
            m_ovf    = 0;
        end else begin
            if (m_active && (cyc - m_start) == FRAME) m_active = 0;
            if (!m_active && mq.size() > 0) begin
                m_byte   = mq.pop_front();
                m_active = 1;
                m_start  = cyc;
            end
            if (we) begin
                if (mq.size() < DEPTH) mq.push_back(d[7:0]);
                else m_ovf = 1;
            end
        end
    endtask

    task automatic cycle(input logic we, input logic [31:0] d, input logic rst);
        int p, idx;
        logic etx, efd, ebusy;
        console_we    = we;
        console_wdata = d;
        reset         = rst;
        @(posedge clk);
        model_edge(we, d, rst);
        #1;
        p   = cyc - m_start;
        idx = p / CPB;
        if (!m_active)     etx = 1'b1;
        else if (idx == 0) etx = 1'b0;
        else if (idx <= 8) etx = m_byte[idx-1];
        else               etx = 1'b1;
        efd   = m_active && (p == FRAME - 1);
        ebusy = m_active || (mq.size() != 0);
        check("tx", 32'(tx), 32'(etx));
        check("frame_done", 32'(frame_done), 32'(efd));
        check("busy", 32'(busy), 32'(ebusy));
        check("fifo_count", 32'(fifo_count), mq.size());
        check("overflow", 32'(overflow), 32'(m_ovf));
        if (cyc < LOGN) begin
            tx_log[cyc]   = tx;
            fd_log[cyc]   = frame_done;
            busy_log[cyc] = busy;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0);
    endtask

    task automatic drain();
        int guard = 0;
        while ((m_active || mq.size() != 0) && guard < 3000) begin
            cycle(1'b0, '0, 1'b0);
            guard++;
        end
        check("drain_timeout", guard >= 3000, 0);
    endtask

    // Rebuild a byte from the logged line by sampling each data bit mid-period.
    function automatic logic [7:0] decode(input int s);
        logic [7:0] r = '0;
        for (int i = 0; i < 8; i++) begin
            int ix = s + CPB * (1 + i) + CPB / 2;
            r[i] = (ix < LOGN) ? tx_log[ix] : 1'bx;
        end
        return r;
    endfunction

    function automatic int fd_pulses(input int a, input int b);
        int n = 0;
        for (int i = a; i <= b && i < LOGN; i++) if (fd_log[i] === 1'b1) n++;
        return n;
    endfunction

    initial begin
        int k, guard;
        logic [7:0] dat [6];
        bit burst;

        // Reset state
        cycle(1'b0, '0, 1'b1);
        cycle(1'b1, 32'h0000_00FF, 1'b1);
        check("reset_tx", 32'(tx), 1);
        check("reset_count", 32'(fifo_count), 0);
        idle(3);

        // 1. Single byte
        cycle(1'b1, 32'h41, 1'b0);
        k = cyc;
        drain();
        idle(2);
        check("t1_start_low", 32'(tx_log[k+1]), 0);
        check("t1_byte", 32'(decode(k+1)), 32'h41);
        check("t1_stop_high", 32'(tx_log[k+37]), 1);
        check("t1_frame_done", 32'(fd_log[k+40]), 1);
        check("t1_busy_low", 32'(busy_log[k+41]), 0);

        // 2. Upper data bits ignored
        cycle(1'b1, 32'hDEAD_BE55, 1'b0);
        k = cyc;
        drain();
        idle(2);
        check("t2_byte", 32'(decode(k+1)), 32'h55);

        // 3. Back-to-back writes produce contiguous frames
        cycle(1'b1, 32'h01, 1'b0);
        k = cyc;
        cycle(1'b1, 32'h02, 1'b0);
        cycle(1'b1, 32'h03, 1'b0);
        check("t3_count_peak", 32'(fifo_count), 2);
        drain();
        idle(2);
        check("t3_byte0", 32'(decode(k+1)), 32'h01);
        check("t3_byte1", 32'(decode(k+1+FRAME)), 32'h02);
        check("t3_byte2", 32'(decode(k+1+2*FRAME)), 32'h03);
        check("t3_busy_held", 32'(busy_log[k+FRAME+1]), 1);
        check("t3_last_done", 32'(fd_log[k+3*FRAME]), 1);

        // 4. Overflow: six writes into a four-deep queue
        k = cyc + 1;
        for (int i = 0; i < 6; i++) cycle(1'b1, $urandom, 1'b0);
        check("t4_overflow_set", 32'(overflow), 1);
        drain();
        idle(2);
        check("t4_frames", fd_pulses(k, cyc), 5);
        cycle(1'b1, $urandom, 1'b0);
        drain();
        check("t4_overflow_sticky", 32'(overflow), 1);
        cycle(1'b0, '0, 1'b1);
        check("t4_overflow_cleared", 32'(overflow), 0);
        idle(2);

        // 5. Full queue accepts a write in the cycle STOP pops
        for (int i = 0; i < 6; i++) dat[i] = 8'($urandom);
        cycle(1'b1, 32'(dat[0]), 1'b0);
        k = cyc;
        for (int i = 1; i < 5; i++) cycle(1'b1, 32'(dat[i]), 1'b0);
        check("t5_full", 32'(fifo_count), 4);
        guard = 0;
        while (!(m_active && (cyc + 1 - m_start) == FRAME) && guard < 200) begin
            cycle(1'b0, '0, 1'b0);
            guard++;
        end
        check("t5_wait_timeout", guard >= 200, 0);
        cycle(1'b1, 32'(dat[5]), 1'b0);
        check("t5_count_kept", 32'(fifo_count), 4);
        check("t5_no_overflow", 32'(overflow), 0);
        drain();
        idle(2);
        for (int i = 0; i < 6; i++) check($sformatf("t5_byte%0d", i), 32'(decode(k+1+i*FRAME)), 32'(dat[i]));

        // 6. Reset in the middle of bit 3 with two bytes queued
        cycle(1'b1, 32'hA5, 1'b0);
        k = cyc;
        cycle(1'b1, 32'h11, 1'b0);
        cycle(1'b1, 32'h22, 1'b0);
        guard = 0;
        while ((cyc + 1) != (k + 1 + CPB * 4 + 1) && guard < 100) begin
            cycle(1'b0, '0, 1'b0);
            guard++;
        end
        check("t6_wait_timeout", guard >= 100, 0);
        cycle(1'b0, '0, 1'b1);
        check("t6_tx_high", 32'(tx), 1);
        check("t6_busy_low", 32'(busy), 0);
        check("t6_count_zero", 32'(fifo_count), 0);
        k = cyc;
        idle(100);
        check("t6_no_frames", fd_pulses(k, cyc), 0);
        cycle(1'b1, 32'h3C, 1'b0);
        k = cyc;
        drain();
        idle(2);
        check("t6_after_reset", 32'(decode(k+1)), 32'h3C);

        // Random traffic with occasional bursts and rare resets
        burst = 0;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 99) < 3) burst = ~burst;
            cycle($urandom_range(0, 99) < (burst ? 60 : 4), $urandom,
                  $urandom_range(0, 999) == 0);
        end
        drain();
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
